fin_test_gen: RTL and testbench

//  Synthesizable multi-channel test-signal generator for the frequency-meter inputs (Fin).

---
 rtl/fin_test_gen_pkg.sv | 20 ++
 rtl/fin_test_chan.sv | 117 +++++++++++
 rtl/fin_test_gen.sv | 102 ++++++++++
 tb/tb_fin_test_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fin_test_gen_pkg.sv
// rtl/fin_test_gen_pkg.sv - register map and CTRL bit layout shared by the Fin test-signal generator
package fin_test_gen_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_HALF = 2'd1;
    localparam logic [1:0] REG_TAPS = 2'd2;
    localparam logic [1:0] REG_CNT  = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_INV  = 2;

    localparam int TAPB_LSB  = 8;

    typedef enum logic {
        MODE_DIV = 1'b0,
        MODE_TAP = 1'b1
    } mode_e;

endpackage

// File: rtl/fin_test_chan.sv
// rtl/fin_test_chan.sv - one generator channel: config regs, half-period divider, tap-AND mux, output flops
module fin_test_chan
    import fin_test_gen_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int CNT_W = 32,
    parameter int TAP_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             we,
    input  logic [1:0]       reg_sel,
    input  logic [31:0]      wdat,
    input  logic [CNT_W-1:0] cnt,
    output logic [31:0]      rdat,
    output logic             fin,
    output logic             fin_n
);

    logic             en;
    logic             inv;
    mode_e            mode;
    logic [DIV_W-1:0] half_reg;
    logic [DIV_W-1:0] half_cur;
    logic [DIV_W-1:0] half_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic [TAP_W-1:0] tap_a;
    logic [TAP_W-1:0] tap_b;
    logic             raw;
    logic             unused_wdat;

    assign unused_wdat = ^wdat;

    // half_cur is only refreshed at a reload so a running half-period finishes with its old length
    always_comb begin
        half_nxt = half_reg;
        if (we && reg_sel == REG_HALF) begin
            half_nxt = wdat[DIV_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            inv      <= 1'b0;
            mode     <= MODE_DIV;
            half_reg <= '0;
            tap_a    <= '0;
            tap_b    <= '0;
        end else if (we) begin
            case (reg_sel)
                REG_CTRL: begin
                    en   <= wdat[CTRL_EN];
                    mode <= mode_e'(wdat[CTRL_MODE]);
                    inv  <= wdat[CTRL_INV];
                end
                REG_HALF: half_reg <= wdat[DIV_W-1:0];
                REG_TAPS: begin
                    tap_a <= wdat[TAP_W-1:0];
                    tap_b <= wdat[TAPB_LSB +: TAP_W];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            half_cur <= '0;
            raw      <= 1'b0;
        end else if (sync || !en) begin
            div_cnt  <= '0;
            half_cur <= half_nxt;
            raw      <= 1'b0;
        end else if (mode == MODE_TAP) begin
            div_cnt  <= '0;
            half_cur <= half_nxt;
            raw      <= cnt[tap_a] & cnt[tap_b];
        end else if (div_cnt == half_cur) begin
            div_cnt  <= '0;
            half_cur <= half_nxt;
            raw      <= ~raw;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin   <= 1'b0;
            fin_n <= 1'b1;
        end else begin
            fin   <= raw ^ inv;
            fin_n <= ~(raw ^ inv);
        end
    end

    always_comb begin
        rdat = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdat[CTRL_EN]   = en;
                rdat[CTRL_MODE] = (mode == MODE_TAP);
                rdat[CTRL_INV]  = inv;
            end
            REG_HALF: rdat[DIV_W-1:0] = half_reg;
            REG_TAPS: begin
                rdat[TAP_W-1:0]         = tap_a;
                rdat[TAPB_LSB +: TAP_W] = tap_b;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fin_test_gen.sv
// rtl/fin_test_gen.sv - multi-channel Fin test-signal generator: tap counter, register decode, read mux, ack
module fin_test_gen
    import fin_test_gen_pkg::*;
#(
    parameter  int CHANNELS = 12,
    parameter  int DIV_W    = 16,
    parameter  int CNT_W    = 32,
    parameter  int TAP_W    = 5,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW       = CH_W + 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sync_i,
    input  logic                cfg_we_i,
    input  logic                cfg_re_i,
    input  logic [AW-1:0]       cfg_addr_i,
    input  logic [31:0]         cfg_dat_i,
    output logic [31:0]         cfg_dat_o,
    output logic                cfg_ack_o,
    output logic [CHANNELS-1:0] fin_o,
    output logic [CHANNELS-1:0] fin_n_o
);

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [CNT_W-1:0] tap_cnt;
    logic [CH_W-1:0]  chan_idx;
    logic [1:0]       reg_sel;
    logic             chan_ok;
    logic [31:0]      ch_rdat [CHANNELS];
    logic [31:0]      rd_mux;

    // reset drops asynchronously but is released only on a clock edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt <= '0;
        end else if (sync_i) begin
            tap_cnt <= '0;
        end else begin
            tap_cnt <= tap_cnt + 1'b1;
        end
    end

    assign chan_idx = cfg_addr_i[AW-1:2];
    assign reg_sel  = cfg_addr_i[1:0];
    assign chan_ok  = int'(chan_idx) < CHANNELS;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        fin_test_chan #(
            .DIV_W (DIV_W),
            .CNT_W (CNT_W),
            .TAP_W (TAP_W)
        ) u_chan (
            .clk     (clk_i),
            .rst_n   (rst_n),
            .sync    (sync_i),
            .we      (cfg_we_i && chan_idx == CH_W'(g)),
            .reg_sel (reg_sel),
            .wdat    (cfg_dat_i),
            .cnt     (tap_cnt),
            .rdat    (ch_rdat[g]),
            .fin     (fin_o[g]),
            .fin_n   (fin_n_o[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_idx == CH_W'(i)) begin
                rd_mux = ch_rdat[i];
            end
        end
        if (reg_sel == REG_CNT) begin
            rd_mux = chan_ok ? 32'(tap_cnt) : 32'd0;
        end
    end

    // a write sharing the cycle with a read suppresses the read data update
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ack_o <= 1'b0;
            cfg_dat_o <= '0;
        end else begin
            cfg_ack_o <= cfg_we_i | cfg_re_i;
            if (cfg_re_i && !cfg_we_i) begin
                cfg_dat_o <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_fin_test_gen.sv
// tb/tb_fin_test_gen.sv - scoreboard bench for fin_test_gen: register port, divider, tap-AND, sync, reset
module tb_fin_test_gen;

    localparam int CH = 12;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          sync_i = 1'b0;
    logic          cfg_we = 1'b0;
    logic          cfg_re = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [31:0]   cfg_wdat = '0;
    logic [31:0]   cfg_dat_o;
    logic          cfg_ack_o;
    logic [CH-1:0] fin_o;
    logic [CH-1:0] fin_n_o;

    fin_test_gen #(.CHANNELS(CH)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .sync_i     (sync_i),
        .cfg_we_i   (cfg_we),
        .cfg_re_i   (cfg_re),
        .cfg_addr_i (cfg_addr),
        .cfg_dat_i  (cfg_wdat),
        .cfg_dat_o  (cfg_dat_o),
        .cfg_ack_o  (cfg_ack_o),
        .fin_o      (fin_o),
        .fin_n_o    (fin_n_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_rd;
        logic [AW-1:0] addr;
        logic [31:0]   exp;
    } exp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  ch;
        logic        val;
    } ev_t;

    exp_t        sb_q[$];
    ev_t         ev_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fin_n_bad = 0;
    logic [31:0] last_exp = '0;
    logic [CH-1:0] prev_fin = '0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    // monitor: samples 1 time unit after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (fin_n_o !== ~fin_o) fin_n_bad++;
        for (int c = 0; c < CH; c++) begin
            if (fin_o[c] !== prev_fin[c]) ev_q.push_back('{cyc: 32'(cyc), ch: 5'(c), val: fin_o[c]});
        end
        prev_fin = fin_o;
        if (cfg_ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.is_rd) check($sformatf("read_addr_%0h", e.addr), cfg_dat_o, e.exp);
            end
        end
    end

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_addr = AW'((ch << 2) | r);
        cfg_wdat = d;
        sb_q.push_back('{is_rd: 1'b0, addr: cfg_addr, exp: 32'd0});
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic rd(input int ch, input int r, input logic [31:0] exp);
        cfg_re   = 1'b1;
        cfg_addr = AW'((ch << 2) | r);
        sb_q.push_back('{is_rd: 1'b1, addr: cfg_addr, exp: exp});
        last_exp = exp;
        @(negedge clk);
        cfg_re = 1'b0;
    endtask

    task automatic wr_rd(input int ch, input int r, input logic [31:0] d);
        cfg_we   = 1'b1;
        cfg_re   = 1'b1;
        cfg_addr = AW'((ch << 2) | r);
        cfg_wdat = d;
        sb_q.push_back('{is_rd: 1'b1, addr: cfg_addr, exp: last_exp});
        @(negedge clk);
        cfg_we = 1'b0;
        cfg_re = 1'b0;
    endtask

    task automatic gap_check(input int ch, input int gap, input int min_n, input string nm);
        int n = 0;
        int bad = 0;
        int last = 0;
        foreach (ev_q[i]) begin
            if (ev_q[i].ch == 5'(ch)) begin
                if (n > 0 && int'(ev_q[i].cyc) - last != gap) bad++;
                last = int'(ev_q[i].cyc);
                n++;
            end
        end
        check({nm, "_gaps"}, 32'(bad), 32'd0);
        check({nm, "_count"}, 32'(n >= min_n), 32'd1);
    endtask

    task automatic first_rise(input int ch, input int after, input int exp_cyc, input string nm);
        int t = -1;
        logic v = 1'b0;
        foreach (ev_q[i]) begin
            if (t < 0 && ev_q[i].ch == 5'(ch) && int'(ev_q[i].cyc) > after) begin
                t = int'(ev_q[i].cyc);
                v = ev_q[i].val;
            end
        end
        check({nm, "_cycle"}, 32'(t - after), 32'(exp_cyc - after));
        check({nm, "_value"}, 32'(v), 32'd1);
    endtask

    initial begin
        int f_cyc;
        int s_cyc;
        int tap_bad;
        int tog[$];
        bit found;

        // reset held for 5 clocks
        repeat (5) @(negedge clk);
        check("rst_fin", 32'(fin_o), 32'd0);
        check("rst_fin_n", 32'(fin_n_o), 32'hFFF);
        check("rst_dat", cfg_dat_o, 32'd0);
        check("rst_ack", 32'(cfg_ack_o), 32'd0);
        rst_i = 1'b1;
        repeat (4) @(negedge clk);
        rd(0, 0, 32'd0);
        rd(5, 1, 32'd0);
        rd(2, 2, 32'd0);
        check("idle_fin", 32'(fin_o), 32'd0);

        // divider: ch0 HALF=3 (8 clk period), ch1 HALF=0 (toggle every clk)
        wr(0, 1, 32'd3);
        wr(0, 0, 32'd1);
        wr(1, 1, 32'd0);
        wr(1, 0, 32'd1);
        ev_q.delete();
        repeat (40) @(negedge clk);
        gap_check(0, 4, 8, "div_half3");
        gap_check(1, 1, 30, "div_half0");

        // HALF 3->1 mid-half: current half still 4 clk, later halves 2 clk
        ev_q.delete();
        found = 0;
        f_cyc = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            foreach (ev_q[j]) if (!found && ev_q[j].ch == 5'd0) begin
                found = 1;
                f_cyc = int'(ev_q[j].cyc);
            end
        end
        check("half_change_seen", 32'(found), 32'd1);
        wr(0, 1, 32'd1);
        repeat (12) @(negedge clk);
        foreach (ev_q[j]) if (ev_q[j].ch == 5'd0 && int'(ev_q[j].cyc) >= f_cyc) tog.push_back(int'(ev_q[j].cyc));
        if (tog.size() >= 4) begin
            check("half_change_gap0", 32'(tog[1] - tog[0]), 32'd4);
            check("half_change_gap1", 32'(tog[2] - tog[1]), 32'd2);
            check("half_change_gap2", 32'(tog[3] - tog[2]), 32'd2);
        end else begin
            check("half_change_toggles", 32'(tog.size()), 32'd4);
        end

        // register port boundaries
        wr(4, 0, 32'hFFFF_FFFF);
        rd(4, 0, 32'd7);
        wr(4, 0, 32'd4);
        wr(2, 2, 32'hFFFF_E8E3);
        rd(2, 2, 32'h0000_0803);
        wr(13, 1, 32'h55);
        rd(13, 1, 32'd0);
        rd(12, 3, 32'd0);
        rd(15, 0, 32'd0);
        wr(5, 1, 32'hFFFF_FFFF);
        rd(5, 1, 32'h0000_FFFF);
        wr_rd(6, 1, 32'h1234);
        rd(6, 1, 32'h1234);
        check("en0_invert", 32'(fin_o[4]), 32'd1);

        // sync with ch0/ch1/ch3 dividing at HALF 3/0/5 and ch2 in tap-AND mode (a=3, b=8)
        wr(2, 0, 32'd3);
        wr(0, 1, 32'd3);
        wr(3, 1, 32'd5);
        wr(3, 0, 32'd1);
        ev_q.delete();
        s_cyc  = cyc + 1;
        sync_i = 1'b1;
        @(negedge clk);
        sync_i = 1'b0;
        rd(0, 3, 32'd0);
        check("sync_zero", {29'd0, fin_o[3], fin_o[1], fin_o[0]}, 32'd0);
        check("tap_k1", 32'(fin_o[2]), 32'd0);
        tap_bad = 0;
        for (int k = 2; k <= 1100; k++) begin
            @(negedge clk);
            if (fin_o[2] !== 1'(((k - 2) >> 3) & ((k - 2) >> 8) & 1)) tap_bad++;
        end
        check("tap_and", 32'(tap_bad), 32'd0);
        first_rise(1, s_cyc + 1, s_cyc + 2, "sync_ch1");
        first_rise(0, s_cyc + 1, s_cyc + 5, "sync_ch0");
        first_rise(3, s_cyc + 1, s_cyc + 7, "sync_ch3");

        // asynchronous reset mid-cycle while channels run
        #2;
        rst_i = 1'b0;
        #1;
        check("async_rst_fin", 32'(fin_o), 32'd0);
        check("async_rst_fin_n", 32'(fin_n_o), 32'hFFF);
        check("fin_n_complement", 32'(fin_n_bad), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
